// File: rtl/bsg_dramsim3_pkg.sv
// Shared types and field-position helpers for the DRAMsim3 address unmapper.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package bsg_dramsim3_pkg;

  // Address-to-DRAM mapping modes, named MSB-first.
  typedef enum logic [1:0] {
    e_ro_ra_bg_ba_co_ch = 2'd0,
    e_ro_ra_bg_ba_ch_co = 2'd1,
    e_ro_ch_ra_ba_bg_co = 2'd2
  } bsg_dramsim3_map_e;

  // Never returns zero, so it is always usable as a port width.
  function automatic int bsg_dramsim3_safe_clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Exact field width; zero for a single-entry dimension.
  function automatic int bsg_dramsim3_lg(input int n);
    return (n <= 1) ? 0 : $clog2(n);
  endfunction

  // Lowest channel-bit position in the flat address for a given mode.
  function automatic int bsg_dramsim3_ch_pos(input bsg_dramsim3_map_e m,
                                             input int off_w, input int co_w,
                                             input int bg_w, input int ba_w,
                                             input int ra_w);
    case (m)
      e_ro_ra_bg_ba_ch_co: return off_w + co_w;
      e_ro_ch_ra_ba_bg_co: return off_w + co_w + bg_w + ba_w + ra_w;
      default:             return off_w;
    endcase
  endfunction

  // Position of bank-group bits once the channel bits have been squeezed out
  // of an e_ro_ch_ra_ba_bg_co address (bg sits directly above the column).
  function automatic int bsg_dramsim3_bg_pos(input int off_w, input int co_w);
    return off_w + co_w;
  endfunction

  // Position of bank bits in the same squeezed e_ro_ch_ra_ba_bg_co address.
  function automatic int bsg_dramsim3_ba_pos(input int off_w, input int co_w,
                                             input int bg_w);
    return off_w + co_w + bg_w;
  endfunction

endpackage

// File: rtl/bsg_dramsim3_addr_decode.sv
// Combinational split of a flat address into channel id and channel address.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller registers the result.
// Ports: mode_i selects the mapping, addr_i is the flat byte address,
//        ch_id_o/ch_addr_o/misaligned_o are the decoded fields.
module bsg_dramsim3_addr_decode
  import bsg_dramsim3_pkg::*;
  #(parameter int channel_addr_width_p = 31
   ,parameter int data_width_p         = 64
   ,parameter int num_channels_p       = 2
   ,parameter int num_columns_p        = 1024
   ,parameter int num_rows_p           = 16384
   ,parameter int num_ba_p             = 4
   ,parameter int num_bg_p             = 4
   ,parameter int num_ranks_p          = 1
   ,localparam int lg_num_channels_lp  = bsg_dramsim3_lg(num_channels_p)
   ,localparam int lg_ch_w_lp          = bsg_dramsim3_safe_clog2(num_channels_p)
   ,localparam int addr_width_lp       = lg_num_channels_lp + channel_addr_width_p
   )
  (input  bsg_dramsim3_map_e                 mode_i
  ,input  logic [addr_width_lp-1:0]          addr_i
  ,output logic [lg_ch_w_lp-1:0]             ch_id_o
  ,output logic [channel_addr_width_p-1:0]   ch_addr_o
  ,output logic                              misaligned_o
  );

  localparam int off_w_lp = bsg_dramsim3_safe_clog2(data_width_p/8);
  localparam int co_w_lp  = bsg_dramsim3_lg(num_columns_p);
  localparam int ba_w_lp  = bsg_dramsim3_lg(num_ba_p);
  localparam int bg_w_lp  = bsg_dramsim3_lg(num_bg_p);
  localparam int ra_w_lp  = bsg_dramsim3_lg(num_ranks_p);
  localparam int ro_w_lp  = bsg_dramsim3_lg(num_rows_p);

  localparam int pos_co_ch_lp = bsg_dramsim3_ch_pos(e_ro_ra_bg_ba_co_ch, off_w_lp, co_w_lp, bg_w_lp, ba_w_lp, ra_w_lp);
  localparam int pos_ch_co_lp = bsg_dramsim3_ch_pos(e_ro_ra_bg_ba_ch_co, off_w_lp, co_w_lp, bg_w_lp, ba_w_lp, ra_w_lp);
  localparam int pos_ro_ch_lp = bsg_dramsim3_ch_pos(e_ro_ch_ra_ba_bg_co, off_w_lp, co_w_lp, bg_w_lp, ba_w_lp, ra_w_lp);

  // Source positions inside the squeezed e_ro_ch_ra_ba_bg_co address.
  localparam int bg_src_lp = bsg_dramsim3_bg_pos(off_w_lp, co_w_lp);
  localparam int ba_src_lp = bsg_dramsim3_ba_pos(off_w_lp, co_w_lp, bg_w_lp);
  localparam int ra_src_lp = ba_src_lp + ba_w_lp;
  localparam int ro_src_lp = ra_src_lp + ra_w_lp;

  // Destination positions in channel-address order ro|ra|bg|ba|co|offset.
  localparam int ba_dst_lp = off_w_lp + co_w_lp;
  localparam int bg_dst_lp = ba_dst_lp + ba_w_lp;
  localparam int ra_dst_lp = bg_dst_lp + bg_w_lp;
  localparam int ro_dst_lp = ra_dst_lp + ra_w_lp;

  typedef logic [addr_width_lp-1:0] flat_t;

  function automatic flat_t mask(input int n);
    flat_t m;
    m = '0;
    for (int i = 0; i < addr_width_lp; i++) begin
      if (i < n) m[i] = 1'b1;
    end
    return m;
  endfunction

  // Remove the channel bits at position p, closing the gap.
  function automatic flat_t squeeze(input flat_t a, input int p);
    return (a & mask(p)) | ((a >> (p + lg_num_channels_lp)) << p);
  endfunction

  flat_t sq;
  flat_t flat;
  flat_t chf;

  always_comb begin
    sq   = '0;
    flat = '0;
    chf  = '0;
    case (mode_i)
      e_ro_ra_bg_ba_ch_co: begin
        chf  = (addr_i >> pos_ch_co_lp) & mask(lg_num_channels_lp);
        flat = squeeze(addr_i, pos_ch_co_lp);
      end
      e_ro_ch_ra_ba_bg_co: begin
        chf  = (addr_i >> pos_ro_ch_lp) & mask(lg_num_channels_lp);
        sq   = squeeze(addr_i, pos_ro_ch_lp);
        // bg sits below ba in this layout; channel order wants ba lowest.
        flat = (((sq >> off_w_lp)  & mask(co_w_lp)) << off_w_lp)
             | (((sq >> ba_src_lp) & mask(ba_w_lp)) << ba_dst_lp)
             | (((sq >> bg_src_lp) & mask(bg_w_lp)) << bg_dst_lp)
             | (((sq >> ra_src_lp) & mask(ra_w_lp)) << ra_dst_lp)
             | (((sq >> ro_src_lp) & mask(ro_w_lp)) << ro_dst_lp);
      end
      default: begin
        chf  = (addr_i >> pos_co_ch_lp) & mask(lg_num_channels_lp);
        flat = squeeze(addr_i, pos_co_ch_lp);
      end
    endcase
    // Byte-offset bits never reach the channel address.
    flat = flat & ~mask(off_w_lp);
  end

  assign ch_id_o      = lg_ch_w_lp'(chf);
  assign ch_addr_o    = channel_addr_width_p'(flat);
  assign misaligned_o = |addr_i[off_w_lp-1:0];

endmodule

// File: rtl/bsg_dramsim3_unmap_pipe.sv
// Unmaps flat addresses to (channel, channel address) with a runtime-selectable mode.
// Latency: 1 cycle from accepted request to v_o.
// Backpressure: valid-ready both sides; a mode change drains the output stage first.
// Ports: clk_i/reset_n_i (async active-low); cfg_v_i/cfg_mode_i/cfg_yumi_o mode change;
//        v_i/addr_i/ready_o request in; v_o/ch_id_o/ch_addr_o/misaligned_o/ready_i result out;
//        mode_o active mode. Define BSG_DRAMSIM3_UNMAP_STATS_EN to add stats_o and
//        misaligned_cnt_o saturating counters of completed output handshakes.
module bsg_dramsim3_unmap_pipe
  import bsg_dramsim3_pkg::*;
  #(parameter int channel_addr_width_p = 31
   ,parameter int data_width_p         = 64
   ,parameter int num_channels_p       = 2
   ,parameter int num_columns_p        = 1024
   ,parameter int num_rows_p           = 16384
   ,parameter int num_ba_p             = 4
   ,parameter int num_bg_p             = 4
   ,parameter int num_ranks_p          = 1
   ,parameter bsg_dramsim3_map_e init_mode_p = e_ro_ra_bg_ba_co_ch
   ,localparam int lg_num_channels_lp  = bsg_dramsim3_lg(num_channels_p)
   ,localparam int lg_ch_w_lp          = bsg_dramsim3_safe_clog2(num_channels_p)
   ,localparam int addr_width_lp       = lg_num_channels_lp + channel_addr_width_p
   )
  (input  logic                             clk_i
  ,input  logic                             reset_n_i
  ,input  logic                             cfg_v_i
  ,input  bsg_dramsim3_map_e                cfg_mode_i
  ,output logic                             cfg_yumi_o
  ,input  logic                             v_i
  ,input  logic [addr_width_lp-1:0]         addr_i
  ,output logic                             ready_o
  ,output logic                             v_o
  ,output logic [lg_ch_w_lp-1:0]            ch_id_o
  ,output logic [channel_addr_width_p-1:0]  ch_addr_o
  ,output logic                             misaligned_o
  ,input  logic                             ready_i
  ,output bsg_dramsim3_map_e                mode_o
`ifdef BSG_DRAMSIM3_UNMAP_STATS_EN
  ,output logic [num_channels_p-1:0][31:0]  stats_o
  ,output logic [31:0]                      misaligned_cnt_o
`endif
  );

  localparam logic [0:0] state_run   = 1'b0;
  localparam logic [0:0] state_drain = 1'b1;

  logic [0:0]        state_r;
  bsg_dramsim3_map_e mode_r;
  logic              cfg_req;
  logic              mode_legal;
  logic              accept;

  logic [lg_ch_w_lp-1:0]           dec_ch_id;
  logic [channel_addr_width_p-1:0] dec_ch_addr;
  logic                            dec_misaligned;

  bsg_dramsim3_addr_decode
    #(.channel_addr_width_p(channel_addr_width_p)
     ,.data_width_p        (data_width_p)
     ,.num_channels_p      (num_channels_p)
     ,.num_columns_p       (num_columns_p)
     ,.num_rows_p          (num_rows_p)
     ,.num_ba_p            (num_ba_p)
     ,.num_bg_p            (num_bg_p)
     ,.num_ranks_p         (num_ranks_p)
     )
    decode
     (.mode_i      (mode_r)
     ,.addr_i      (addr_i)
     ,.ch_id_o     (dec_ch_id)
     ,.ch_addr_o   (dec_ch_addr)
     ,.misaligned_o(dec_misaligned)
     );

  // cfg_v_i is still high during the acknowledge cycle; that is not a new request.
  assign cfg_req    = cfg_v_i & ~cfg_yumi_o;
  assign ready_o    = (state_r == state_run) & ~cfg_req & (~v_o | ready_i);
  assign accept     = v_i & ready_o;
  assign mode_legal = cfg_mode_i inside {e_ro_ra_bg_ba_co_ch, e_ro_ra_bg_ba_ch_co, e_ro_ch_ra_ba_bg_co};
  assign mode_o     = mode_r;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r    <= state_run;
      mode_r     <= init_mode_p;
      cfg_yumi_o <= 1'b0;
    end else begin
      cfg_yumi_o <= 1'b0;
      case (state_r)
        state_run: begin
          if (cfg_req) state_r <= state_drain;
        end
        default: begin
          // Switch only once the output stage is empty so no result mixes modes.
          if (~v_o) begin
            state_r    <= state_run;
            cfg_yumi_o <= 1'b1;
            if (mode_legal) mode_r <= cfg_mode_i;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      v_o          <= 1'b0;
      ch_id_o      <= '0;
      ch_addr_o    <= '0;
      misaligned_o <= 1'b0;
    end else if (accept) begin
      v_o          <= 1'b1;
      ch_id_o      <= dec_ch_id;
      ch_addr_o    <= dec_ch_addr;
      misaligned_o <= dec_misaligned;
    end else if (ready_i) begin
      v_o <= 1'b0;
    end
  end

`ifdef BSG_DRAMSIM3_UNMAP_STATS_EN
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      stats_o          <= '0;
      misaligned_cnt_o <= '0;
    end else if (v_o & ready_i) begin
      for (int c = 0; c < num_channels_p; c++) begin
        if ((ch_id_o == lg_ch_w_lp'(c)) && (stats_o[c] != 32'hffff_ffff))
          stats_o[c] <= stats_o[c] + 32'd1;
      end
      if (misaligned_o && (misaligned_cnt_o != 32'hffff_ffff))
        misaligned_cnt_o <= misaligned_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bsg_dramsim3_unmap_pipe.sv
// Self-checking bench for bsg_dramsim3_unmap_pipe: directed cases plus random traffic
// in every mode, checked against an arithmetic field-extraction model.
// Latency: n/a. Backpressure: randomised ready_i.
module tb_bsg_dramsim3_unmap_pipe;
  import bsg_dramsim3_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cfg_v;
  bsg_dramsim3_map_e cfg_mode;
  logic              cfg_yumi;
  logic              v_in;
  logic [31:0]       addr;
  logic              rdy_out;
  logic              v_out;
  logic [0:0]        ch_id;
  logic [30:0]       ch_addr;
  logic              mis;
  logic              rdy_in;
  bsg_dramsim3_map_e mode_cur;
`ifdef BSG_DRAMSIM3_UNMAP_STATS_EN
  logic [1:0][31:0]  stats;
  logic [31:0]       mis_cnt;
`endif

  int n_chk = 0;
  int n_err = 0;

  // Model state.
  bit          exp_v;
  bit          exp_ch;
  logic [30:0] exp_addr;
  bit          exp_mis;
  int          cur_mode;

  always #5 clk = ~clk;

  bsg_dramsim3_unmap_pipe
    #(.channel_addr_width_p(31), .data_width_p(64), .num_channels_p(2)
     ,.num_columns_p(1024), .num_rows_p(16384), .num_ba_p(4), .num_bg_p(4)
     ,.num_ranks_p(1), .init_mode_p(e_ro_ra_bg_ba_co_ch))
    dut
     (.clk_i(clk), .reset_n_i(rst_n)
     ,.cfg_v_i(cfg_v), .cfg_mode_i(cfg_mode), .cfg_yumi_o(cfg_yumi)
     ,.v_i(v_in), .addr_i(addr), .ready_o(rdy_out)
     ,.v_o(v_out), .ch_id_o(ch_id), .ch_addr_o(ch_addr), .misaligned_o(mis)
     ,.ready_i(rdy_in), .mode_o(mode_cur)
`ifdef BSG_DRAMSIM3_UNMAP_STATS_EN
     ,.stats_o(stats), .misaligned_cnt_o(mis_cnt)
`endif
     );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Field extraction by plain arithmetic: 8-byte words, 1024 columns, 4 bg, 4 ba,
  // 1 rank, 2 channels.
  function automatic bit ref_ch(input int m, input logic [31:0] a);
    longint unsigned u = a;
    case (m)
      1:       return ((u / 8192) % 2) != 0;
      2:       return ((u / 131072) % 2) != 0;
      default: return ((u / 8) % 2) != 0;
    endcase
  endfunction

  function automatic logic [30:0] ref_addr(input int m, input logic [31:0] a);
    longint unsigned u = a;
    longint unsigned co, bg, ba, ro, r;
    co = (u / 8) % 1024;
    case (m)
      1: r = ((u / 16384) * 1024 + co) * 8;
      2: begin
        bg = (u / 8192) % 4;
        ba = (u / 32768) % 4;
        ro = u / 262144;
        r  = (((ro * 4 + bg) * 4 + ba) * 1024 + co) * 8;
      end
      default: r = (u / 16) * 8;
    endcase
    return r[30:0];
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Inputs are already driven; check ready_o, advance the model over one edge,
  // then check the registered outputs.
  task automatic step_check(input string tag);
    bit exp_rdy;
    #1;
    exp_rdy = !cfg_v && (!exp_v || rdy_in);
    chk({tag, "_ready"}, rdy_out, exp_rdy);
    if (v_in && exp_rdy) begin
      exp_v    = 1'b1;
      exp_ch   = ref_ch(cur_mode, addr);
      exp_addr = ref_addr(cur_mode, addr);
      exp_mis  = (addr[2:0] != 3'd0);
    end else if (rdy_in) begin
      exp_v = 1'b0;
    end
    tick();
    chk({tag, "_v"}, v_out, exp_v);
    if (exp_v) begin
      chk({tag, "_ch"}, ch_id, exp_ch);
      chk({tag, "_addr"}, ch_addr, exp_addr);
      chk({tag, "_mis"}, mis, exp_mis);
    end
  endtask

  // Requires an empty output stage; returns in the acknowledge cycle with cfg_v low.
  task automatic do_cfg(input int m);
    int waited;
    cfg_mode = bsg_dramsim3_map_e'(2'(m));
    cfg_v    = 1'b1;
    v_in     = 1'b0;
    rdy_in   = 1'b1;
    waited   = 0;
    while (!cfg_yumi && waited < 10) begin
      tick();
      waited++;
    end
    chk("cfg_ack", cfg_yumi, 1'b1);
    chk("cfg_mode", mode_cur, 64'(m));
    cfg_v = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    int waited;
    rst_n = 1'b0; cfg_v = 1'b0; cfg_mode = e_ro_ra_bg_ba_co_ch;
    v_in = 1'b0; addr = '0; rdy_in = 1'b0;
    exp_v = 1'b0; exp_ch = 1'b0; exp_addr = '0; exp_mis = 1'b0; cur_mode = 0;
    #12;
    chk("rst_v", v_out, 0);
    chk("rst_mode", mode_cur, e_ro_ra_bg_ba_co_ch);
    chk("rst_yumi", cfg_yumi, 0);
    chk("rst_ch", ch_id, 0);
    chk("rst_addr", ch_addr, 0);
    chk("rst_mis", mis, 0);
    rst_n = 1'b1;
    tick();

    // Basic decode in the reset mode.
    v_in = 1'b1; addr = 32'h48; rdy_in = 1'b1;
    step_check("co_ch");
    chk("co_ch_ch_k", ch_id, 1);
    chk("co_ch_addr_k", ch_addr, 32'h20);
    chk("co_ch_mis_k", mis, 0);

    addr = 32'h41;
    step_check("misalign");
    chk("misalign_k", mis, 1);
    chk("misalign_addr_k", ch_addr, 32'h20);

    // Stall three cycles: ready_o low, outputs frozen.
    rdy_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      addr = 32'h1238 + 32'(i * 8);
      step_check("stall");
      chk("stall_ready_k", rdy_out, 0);
      chk("stall_hold_k", ch_addr, 32'h20);
    end
    rdy_in = 1'b1; addr = 32'h1238;
    step_check("resume");
    addr = 32'h5550;
    step_check("b2b");
    chk("b2b_v_k", v_out, 1);

    // Mode change colliding with a request while the output is stalled.
    rdy_in = 1'b0; v_in = 1'b1; addr = 32'h2008;
    cfg_v = 1'b1; cfg_mode = e_ro_ra_bg_ba_ch_co;
    #1;
    chk("cfg_wins_ready", rdy_out, 0);
    tick();
    chk("cfg_hold_v", v_out, 1);
    chk("cfg_hold_addr", ch_addr, exp_addr);
    tick();
    chk("cfg_no_early_ack", cfg_yumi, 0);
    rdy_in = 1'b1; v_in = 1'b0;
    tick();
    chk("drain_v", v_out, 0);
    chk("drain_mode_old", mode_cur, e_ro_ra_bg_ba_co_ch);
    waited = 0;
    while (!cfg_yumi && waited < 8) begin
      tick();
      waited++;
    end
    chk("yumi_latency", 64'(waited), 1);
    chk("mode_new", mode_cur, e_ro_ra_bg_ba_ch_co);
    cfg_v = 1'b0; cur_mode = 1; exp_v = 1'b0;
    v_in = 1'b1; addr = 32'h2008; rdy_in = 1'b1;
    step_check("ch_co");
    chk("yumi_one_cycle", cfg_yumi, 0);
    chk("ch_co_ch_k", ch_id, 1);
    chk("ch_co_addr_k", ch_addr, 32'h8);

    // Illegal mode: acknowledged, mode unchanged.
    v_in = 1'b0;
    step_check("pre_illegal");
    cfg_v = 1'b1; cfg_mode = bsg_dramsim3_map_e'(2'd3);
    waited = 0;
    while (!cfg_yumi && waited < 10) begin
      tick();
      waited++;
    end
    chk("illegal_ack", cfg_yumi, 1);
    chk("illegal_keeps_mode", mode_cur, e_ro_ra_bg_ba_ch_co);
    cfg_v = 1'b0;
    tick();

    // Random traffic in each mode.
    for (int m = 0; m < 3; m++) begin
      do_cfg(m);
      cur_mode = m;
      exp_v = 1'b0;
      for (int i = 0; i < 150; i++) begin
        v_in   = ($urandom_range(0, 3) != 0);
        rdy_in = ($urandom_range(0, 2) != 0);
        addr   = $urandom;
        if ($urandom_range(0, 3) != 0) addr[2:0] = 3'd0;
        step_check("rand");
      end
      v_in = 1'b0; rdy_in = 1'b1;
      step_check("rand_drain");
    end

    // Asynchronous reset while a result is held.
    v_in = 1'b1; addr = 32'h48; rdy_in = 1'b0;
    step_check("pre_rst");
    v_in = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_v", v_out, 0);
    chk("arst_mode", mode_cur, e_ro_ra_bg_ba_co_ch);
    #2;
    rst_n = 1'b1;
    tick();
    exp_v = 1'b0; cur_mode = 0; rdy_in = 1'b1;
    for (int i = 0; i < 3; i++) step_check("post_rst");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
